logic_op_resp: RTL
==================

LOGIC_OP_RESP -- requirements
Module: logic_op_resp

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of result-FIFO entries; DEPTH SHALL be a power of two and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the request-side operand valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 The block SHALL have port in_op, input, 2 bits: 00 logical AND, 01 logical OR, 10 logical NOT, 11 reserved.
REQ-008 The block SHALL have ports in_a and in_b, input, WIDTH bits each: the operands; in_b SHALL be ignored for NOT.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the FIFO head holds a result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the head result.
REQ-011 The block SHALL have port out_c, output, WIDTH bits: the head result.
REQ-012 The block SHALL have port out_err, output, 1 bit: the head result came from a reserved op.
REQ-013 The block SHALL have port err_count, output, 8 bits: the count of accepted reserved-op requests.

Function
REQ-014 A request SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-015 A response SHALL be popped on a rising edge where out_valid=1 and out_ready=1.
REQ-016 in_ready SHALL be 1 exactly when the registered FIFO occupancy is less than DEPTH; it SHALL NOT depend combinationally on out_ready, so there is no pass-through when full.
REQ-017 For AND, the result SHALL be ((|in_a) && (|in_b)) zero-extended to WIDTH.
REQ-018 For OR, the result SHALL be ((|in_a) || (|in_b)) zero-extended to WIDTH.
REQ-019 For NOT, the result SHALL be (in_a == 0) zero-extended to WIDTH.
REQ-020 For reserved op 11, the result SHALL be all zeros with out_err=1; for the other ops out_err SHALL be 0.
REQ-021 The result and error bit SHALL be written into the FIFO at the tail on the accepting edge.
REQ-022 out_valid SHALL go high in the cycle after acceptance, giving 1-cycle latency when the FIFO was empty.
REQ-023 out_valid SHALL be 1 exactly when occupancy is not zero.
REQ-024 out_c and out_err SHALL show the head entry; when empty they SHALL hold 0.
REQ-025 Results SHALL leave the FIFO in acceptance order.
REQ-026 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-027 Occupancy SHALL be log2(DEPTH)+1 bits.
REQ-028 On a simultaneous push and pop, occupancy SHALL be unchanged and both pointers SHALL advance; this is legal at any occupancy from 1 to DEPTH-1.
REQ-029 At occupancy 0, a simultaneous push and pop SHALL NOT occur, because out_valid=0.
REQ-030 Requests while in_ready=0 SHALL be ignored with no state change.
REQ-031 A pop while out_valid=0 SHALL be ignored.
REQ-032 err_count SHALL increment on each accepted reserved-op request and saturate at 255.

Reset
REQ-033 While rst=1 on a rising edge, occupancy, both pointers, out_valid, out_c, out_err and err_count SHALL be 0.
REQ-034 While rst=1 on a rising edge, in_ready SHALL be 1 from the first cycle after reset.
REQ-035 Reset SHALL override any concurrent push or pop.
REQ-036 Reset asserted mid-operation SHALL discard all FIFO contents.
REQ-037 The first accepted request after reset deassertion SHALL produce out_valid=1 one cycle later.

Verification
REQ-038 The bench SHALL cover AND: requests (a=000,b=101), (011,101), (111,000) with out_ready=1 -> out_c=000, 001, 000 on consecutive cycles, each one cycle after acceptance, with out_err=0.
REQ-039 The bench SHALL cover OR and NOT: OR (000,000), OR (011,101), NOT a=000, NOT a=011 -> out_c=000, 001, 001, 000, in order.
REQ-040 The bench SHALL cover full and backpressure: out_ready=0 with 5 back-to-back requests -> first 4 accepted, in_ready=0 after the 4th, 5th held off; raising out_ready -> 4 results in order, 5th accepted the cycle after the first pop.
REQ-041 The bench SHALL cover simultaneous push and pop: occupancy 2, push and pop on the same edge -> occupancy stays 2; 2*DEPTH+1 such operations -> pointers wrap with no reordering.
REQ-042 The bench SHALL cover reserved op: 3 requests with op=11 -> out_c=000, out_err=1 each, err_count=3; 300 such requests -> err_count=255.
REQ-043 The bench SHALL cover mid-operation reset: 3 entries queued, rst=1 for one edge -> out_valid=0, err_count=0, in_ready=1; next request with AND (001,001) -> out_c=001 one cycle later.

Source files
------------

// File: rtl/logic_op_resp.sv
// Logical-op unit (AND/OR/NOT) with a result FIFO and error counter.
// Ports: clk, rst, in_* request handshake, out_* response head, err_count.
module logic_op_resp #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic             out_err,
  output logic [7:0]       err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH:0]  mem_q [DEPTH];
  logic [WIDTH:0]  mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] res;
  logic             res_err;
  logic             push;
  logic             pop;

  // Full/empty come only from registered occupancy, so a pop never
  // opens in_ready in the same cycle.
  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign err_count = err_cnt_q;

  always_comb begin
    out_c   = '0;
    out_err = 1'b0;
    if (out_valid) begin
      out_c   = mem_q[rd_ptr_q][WIDTH-1:0];
      out_err = mem_q[rd_ptr_q][WIDTH];
    end
  end

  always_comb begin
    res     = '0;
    res_err = 1'b0;
    unique case (in_op)
      2'b00: res[0] = (|in_a) && (|in_b);
      2'b01: res[0] = (|in_a) || (|in_b);
      2'b10: res[0] = (in_a == '0);
      default: res_err = 1'b1;
    endcase
  end

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_cnt_d = err_cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = {res_err, res};
      // DEPTH is a power of two, so the pointer wraps naturally.
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push && res_err && (err_cnt_q != 8'hff)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
